// File: rtl/demux_cl_seq_if.sv
// ---------------------------------------------------------------------------
// demux_cl_seq_if
// Bus bundle for the 1-to-8 sequential demultiplexer.
//   Serial side : din, sel, sel_en, in_valid, flush, in_ready
//   Word side   : dout, lane_mask, out_valid, out_ready, ovr_err
// Modports:
//   master : the producer/consumer environment around the block
//   slave  : the demux itself
// ---------------------------------------------------------------------------
interface demux_cl_seq_if #(
    parameter int NLANES = 8,
    parameter int SEL_W  = 3
);
    logic              din;
    logic [SEL_W-1:0]  sel;
    logic              sel_en;
    logic              in_valid;
    logic              in_ready;
    logic              flush;
    logic [NLANES-1:0] dout;
    logic [NLANES-1:0] lane_mask;
    logic              out_valid;
    logic              out_ready;
    logic              ovr_err;

    modport master (
        output din, sel, sel_en, in_valid, flush, out_ready,
        input  in_ready, dout, lane_mask, out_valid, ovr_err
    );

    modport slave (
        input  din, sel, sel_en, in_valid, flush, out_ready,
        output in_ready, dout, lane_mask, out_valid, ovr_err
    );
endinterface

// File: rtl/demux_cl_seq.sv
// ---------------------------------------------------------------------------
// demux_cl_seq
// Sequential 1-to-NLANES demultiplexer / deserializer. Each accepted serial
// bit is steered into a lane register chosen by an explicit select or by an
// auto-increment pointer. The assembled word is presented with valid/ready
// once every lane has been written, or earlier on flush.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset (synchronous release upstream)
//   bus    : demux_cl_seq_if.slave
//            din/sel/sel_en/in_valid/flush in, in_ready out
//            dout/lane_mask/out_valid/ovr_err out, out_ready in
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no lane written yet in this frame (mask == 0)
// FILL   | partial frame, at least one lane written, not all
// HOLD   | word presented on dout/lane_mask, waiting for out_ready
// ---------------------------------------------------------------------------
module demux_cl_seq #(
    parameter int NLANES = 8,
    parameter int SEL_W  = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    demux_cl_seq_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [NLANES-1:0] ALL_ONES = {NLANES{1'b1}};
    localparam logic [NLANES-1:0] ONE      = {{(NLANES-1){1'b0}}, 1'b1};

    state_t            r_state;
    logic [NLANES-1:0] r_dout;
    logic [NLANES-1:0] r_mask;
    logic [SEL_W-1:0]  r_ptr;
    logic              r_out_valid;
    logic              r_ovr_err;

    state_t            w_state_nxt;
    logic [NLANES-1:0] w_dout_nxt;
    logic [NLANES-1:0] w_mask_nxt;
    logic [SEL_W-1:0]  w_ptr_nxt;
    logic              w_out_valid_nxt;
    logic              w_ovr_err_nxt;

    logic              w_in_ready;
    logic              w_accept;
    logic [SEL_W-1:0]  w_lane;
    logic [NLANES-1:0] w_lane_bit;
    logic [NLANES-1:0] w_mask_wr;
    logic [NLANES-1:0] w_dout_wr;

    // Ready depends only on the state register so it never loops back
    // through the producer's valid.
    assign w_in_ready = (r_state != S_HOLD);
    assign w_accept   = bus.in_valid & w_in_ready;
    assign w_lane     = bus.sel_en ? bus.sel : r_ptr;
    assign w_lane_bit = ONE << w_lane;
    assign w_mask_wr  = r_mask | w_lane_bit;
    assign w_dout_wr  = bus.din ? (r_dout | w_lane_bit) : (r_dout & ~w_lane_bit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_dout      <= '0;
            r_mask      <= '0;
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_ovr_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_dout      <= w_dout_nxt;
            r_mask      <= w_mask_nxt;
            r_ptr       <= w_ptr_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_ovr_err   <= w_ovr_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_dout_nxt      = r_dout;
        w_mask_nxt      = r_mask;
        w_ptr_nxt       = r_ptr;
        w_out_valid_nxt = r_out_valid;
        w_ovr_err_nxt   = 1'b0;

        case (r_state)
            S_IDLE, S_FILL: begin
                if (w_accept) begin
                    w_dout_nxt    = w_dout_wr;
                    w_mask_nxt    = w_mask_wr;
                    // The pointer advances on every accept, even explicit ones,
                    // so mixed-mode frames keep a predictable auto sequence.
                    w_ptr_nxt     = r_ptr + 1'b1;
                    w_ovr_err_nxt = |(r_mask & w_lane_bit);
                end

                if (w_accept && (w_mask_wr == ALL_ONES)) begin
                    w_state_nxt     = S_HOLD;
                    w_out_valid_nxt = 1'b1;
                end else if (bus.flush && (w_accept || (r_state == S_FILL))) begin
                    // A flush with nothing written is ignored; a same-cycle
                    // write lands in the held word.
                    w_state_nxt     = S_HOLD;
                    w_out_valid_nxt = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = S_FILL;
                end
            end

            S_HOLD: begin
                if (bus.out_ready) begin
                    w_state_nxt     = S_IDLE;
                    w_dout_nxt      = '0;
                    w_mask_nxt      = '0;
                    w_ptr_nxt       = '0;
                    w_out_valid_nxt = 1'b0;
                end
            end

            default: begin
                w_state_nxt     = S_IDLE;
                w_dout_nxt      = '0;
                w_mask_nxt      = '0;
                w_ptr_nxt       = '0;
                w_out_valid_nxt = 1'b0;
            end
        endcase
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.dout      = r_dout;
    assign bus.lane_mask = r_mask;
    assign bus.out_valid = r_out_valid;
    assign bus.ovr_err   = r_ovr_err;

endmodule

// File: tb/tb_demux_cl_seq.sv
module tb_demux_cl_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    demux_cl_seq_if #(.NLANES(8), .SEL_W(3)) bus ();

    demux_cl_seq #(.NLANES(8), .SEL_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic       v;
        logic       se;
        logic [2:0] sel;
        logic       din;
        logic       fl;
        logic       ordy;
        logic [7:0] e_dout;
        logic [7:0] e_mask;
        logic       e_ov;
        logic       e_ir;
        logic       e_ovr;
        logic       push;
    } vec_t;

    vec_t        tbl[$];
    logic [15:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic v, input logic se, input logic [2:0] sel, input logic din,
                       input logic fl, input logic ordy, input logic [7:0] e_dout,
                       input logic [7:0] e_mask, input logic e_ov, input logic e_ir,
                       input logic e_ovr, input logic push);
        vec_t r;
        r.v = v; r.se = se; r.sel = sel; r.din = din; r.fl = fl; r.ordy = ordy;
        r.e_dout = e_dout; r.e_mask = e_mask; r.e_ov = e_ov; r.e_ir = e_ir;
        r.e_ovr = e_ovr; r.push = push;
        tbl.push_back(r);
    endtask

    task automatic drive(input logic v, input logic se, input logic [2:0] sel,
                         input logic din, input logic fl, input logic ordy);
        @(negedge clk);
        bus.in_valid  = v;
        bus.sel_en    = se;
        bus.sel       = sel;
        bus.din       = din;
        bus.flush     = fl;
        bus.out_ready = ordy;
    endtask

    task automatic chk_outs(input string tag, input logic [7:0] e_dout, input logic [7:0] e_mask,
                            input logic e_ov, input logic e_ir, input logic e_ovr);
        chk({tag, " dout"},      bus.dout,               e_dout);
        chk({tag, " lane_mask"}, bus.lane_mask,          e_mask);
        chk({tag, " out_valid"}, {7'd0, bus.out_valid},  {7'd0, e_ov});
        chk({tag, " in_ready"},  {7'd0, bus.in_ready},   {7'd0, e_ir});
        chk({tag, " ovr_err"},   {7'd0, bus.ovr_err},    {7'd0, e_ovr});
    endtask

    // Scoreboard consumer: every completed handshake must match the oldest
    // word the stimulus announced.
    always @(posedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got word %h/%h expected none", bus.dout, bus.lane_mask);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                chk("sb dout", bus.dout, e[15:8]);
                chk("sb lane_mask", bus.lane_mask, e[7:0]);
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.sel_en    = 1'b0;
        bus.sel       = 3'd0;
        bus.din       = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;

        //  v  se sel din fl ordy dout   mask   ov ir ovr push
        // auto mode: 1,0,1,1,0,0,1,0 -> 8'b0100_1101
        add(1, 0, 0, 1, 0, 0, 8'h01, 8'h01, 0, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0, 8'h01, 8'h03, 0, 1, 0, 0);
        add(1, 0, 0, 1, 0, 0, 8'h05, 8'h07, 0, 1, 0, 0);
        add(1, 0, 0, 1, 0, 0, 8'h0D, 8'h0F, 0, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0, 8'h0D, 8'h1F, 0, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0, 8'h0D, 8'h3F, 0, 1, 0, 0);
        add(1, 0, 0, 1, 0, 0, 8'h4D, 8'h7F, 0, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0, 8'h4D, 8'hFF, 1, 0, 0, 1);
        add(1, 0, 0, 1, 0, 0, 8'h4D, 8'hFF, 1, 0, 0, 0);
        add(1, 0, 0, 1, 0, 1, 8'h00, 8'h00, 0, 1, 0, 0);
        // explicit select 7..0, din=1 only on lane 5
        add(1, 1, 7, 0, 0, 0, 8'h00, 8'h80, 0, 1, 0, 0);
        add(1, 1, 6, 0, 0, 0, 8'h00, 8'hC0, 0, 1, 0, 0);
        add(1, 1, 5, 1, 0, 0, 8'h20, 8'hE0, 0, 1, 0, 0);
        add(1, 1, 4, 0, 0, 0, 8'h20, 8'hF0, 0, 1, 0, 0);
        add(1, 1, 3, 0, 0, 0, 8'h20, 8'hF8, 0, 1, 0, 0);
        add(1, 1, 2, 0, 0, 0, 8'h20, 8'hFC, 0, 1, 0, 0);
        add(1, 1, 1, 0, 0, 0, 8'h20, 8'hFE, 0, 1, 0, 0);
        add(1, 1, 0, 0, 0, 0, 8'h20, 8'hFF, 1, 0, 0, 1);
        add(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 1, 0, 0);
        // overwrite lane 3, then flush the partial frame from FILL
        add(1, 1, 3, 1, 0, 0, 8'h08, 8'h08, 0, 1, 0, 0);
        add(1, 1, 3, 0, 0, 0, 8'h00, 8'h08, 0, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0, 8'h00, 8'h08, 0, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0, 8'h00, 8'h08, 1, 0, 0, 1);
        add(0, 0, 0, 0, 1, 1, 8'h00, 8'h00, 0, 1, 0, 0);
        // flush with a 4th accept: 1,1,0,(1+flush) -> 0B/0F
        add(1, 0, 0, 1, 0, 0, 8'h01, 8'h01, 0, 1, 0, 0);
        add(1, 0, 0, 1, 0, 0, 8'h03, 8'h03, 0, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0, 8'h03, 8'h07, 0, 1, 0, 0);
        add(1, 0, 0, 1, 1, 0, 8'h0B, 8'h0F, 1, 0, 0, 1);
        add(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 1, 0, 0);
        // flush alone in IDLE is ignored
        add(0, 0, 0, 1, 1, 0, 8'h00, 8'h00, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0);
        // flush together with the first accept in IDLE
        add(1, 0, 0, 1, 1, 0, 8'h01, 8'h01, 1, 0, 0, 1);
        add(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 1, 0, 0);
        // mixed modes: ptr advances on explicit writes too
        add(1, 1, 5, 1, 0, 0, 8'h20, 8'h20, 0, 1, 0, 0);
        add(1, 0, 0, 1, 0, 0, 8'h22, 8'h22, 0, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0, 8'h22, 8'h22, 1, 0, 0, 1);
        add(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 1, 0, 0);

        repeat (2) @(negedge clk);
        chk_outs("reset", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].se, tbl[i].sel, tbl[i].din, tbl[i].fl, tbl[i].ordy);
            if (tbl[i].push) exp_q.push_back({tbl[i].e_dout, tbl[i].e_mask});
            @(posedge clk);
            #1;
            chk_outs($sformatf("vec%0d", i), tbl[i].e_dout, tbl[i].e_mask,
                     tbl[i].e_ov, tbl[i].e_ir, tbl[i].e_ovr);
        end

        // backpressure: full word of ones held for 5 cycles under in_valid
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 0, 1, 0, 0);
            if (i == 7) exp_q.push_back({8'hFF, 8'hFF});
        end
        @(posedge clk); #1;
        chk_outs("bp_full", 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 0, 0, 0);
            @(posedge clk); #1;
            chk_outs($sformatf("bp_hold%0d", i), 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
        end
        drive(1, 0, 0, 0, 0, 1);
        @(posedge clk); #1;
        chk_outs("bp_release", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

        // partial frame 1,0,1 then asynchronous reset between edges
        drive(1, 0, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk_outs("pre_reset", 8'h05, 8'h07, 1'b0, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_outs("async_reset", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, 0, 1, 0, 0);
        @(posedge clk); #1;
        chk_outs("restart_lane0", 8'h01, 8'h01, 1'b0, 1'b1, 1'b0);
        drive(0, 0, 0, 0, 0, 0);

        repeat (2) @(negedge clk);
        chk("sb_drained", 8'(exp_q.size()), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
